// File: rtl/dino_pkg.sv
// Shared types and constants for the dinosaur sprite block.
package dino_pkg;

  typedef enum logic [1:0] {
    GROUND  = 2'd0,
    ASCEND  = 2'd1,
    DESCEND = 2'd2
  } dino_state_e;

  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 16;
  localparam logic [8:0] FRAME_TICK_ROW = 9'd480;

endpackage

// File: rtl/dino_rom.sv
// Combinational 16x16 dinosaur bitmap; frame 1 swaps the leg rows (12..15).
module dino_rom
  import dino_pkg::*;
(
  input  logic       frame,
  input  logic [3:0] y,
  input  logic [3:0] x,
  output logic       pix
);

  logic [15:0] row_bits;

  // Row lookup; MSB is the leftmost column of the sprite.
  always_comb begin
    row_bits = 16'h0000;
    case (y)
      4'd0:    row_bits = 16'h007E;
      4'd1:    row_bits = 16'h00FF;
      4'd2:    row_bits = 16'h00DF;
      4'd3:    row_bits = 16'h00FF;
      4'd4:    row_bits = 16'h00F0;
      4'd5:    row_bits = 16'h00FC;
      4'd6:    row_bits = 16'h81F0;
      4'd7:    row_bits = 16'hC3F0;
      4'd8:    row_bits = 16'hE7FC;
      4'd9:    row_bits = 16'hFFF4;
      4'd10:   row_bits = 16'h7FF0;
      4'd11:   row_bits = 16'h3FE0;
      4'd12:   row_bits = frame ? 16'h1F80 : 16'h1FC0;
      4'd13:   row_bits = frame ? 16'h1900 : 16'h0D80;
      4'd14:   row_bits = frame ? 16'h1100 : 16'h0880;
      4'd15:   row_bits = frame ? 16'h1980 : 16'h0CC0;
      default: row_bits = 16'h0000;
    endcase
  end

  assign pix = row_bits[4'd15 - x];

endmodule

// File: rtl/dino_sprite.sv
// Dinosaur jump physics (updated once per frame on the blanking tick) and sprite pixel.
// Optional leg animation when DINO_ANIM_EN is defined.
module dino_sprite
  import dino_pkg::*;
#(
  parameter int DINO_X     = 64,
  parameter int GROUND_ROW = 400,
  parameter int JUMP_V     = 12,
  parameter int GRAVITY    = 1
) (
  input  logic       vga_clk,
  input  logic       rst,
  input  logic       jump,
  input  logic [8:0] row_addr,
  input  logic [9:0] col_addr,
  output logic       px_dinosaur,
  output logic [6:0] height,
  output logic       airborne
);

  localparam logic [9:0]        X_LO     = 10'(DINO_X);
  localparam logic [9:0]        X_HI     = 10'(DINO_X + SPRITE_W - 1);
  localparam logic [9:0]        TOP_REST = 10'(GROUND_ROW - SPRITE_H);
  localparam logic signed [5:0] JUMP_V_S = 6'(JUMP_V);
  localparam logic signed [5:0] GRAV_S   = 6'(GRAVITY);

  dino_state_e        state_q, state_d;
  logic [6:0]         height_q, height_d;
  logic signed [5:0]  vel_q, vel_d;
  logic               pending_q, pending_d;
  logic               jump_q, jump_d;

  logic               tick;
  logic               rise;
  logic signed [5:0]  vel_dec;
  logic signed [7:0]  next_h;

  assign tick    = (row_addr == FRAME_TICK_ROW) && (col_addr == 10'd0);
  assign rise    = jump && !jump_q;
  assign vel_dec = vel_q - GRAV_S;
  assign next_h  = $signed({1'b0, height_q}) + $signed({{2{vel_q[5]}}, vel_q});

  // Jump capture and per-frame physics.
  always_comb begin
    state_d   = state_q;
    height_d  = height_q;
    vel_d     = vel_q;
    pending_d = pending_q;
    jump_d    = jump;

    // A press on a tick cycle survives that tick and is used on the next one.
    if (rise && (state_q == GROUND)) begin
      pending_d = 1'b1;
    end else if (tick) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    if (tick) begin
      case (state_q)
        GROUND: begin
          if (pending_q) begin
            vel_d   = JUMP_V_S;
            state_d = ASCEND;
          end else begin
            state_d = GROUND;
          end
        end
        ASCEND: begin
          height_d = height_q + {1'b0, vel_q};
          vel_d    = vel_dec;
          if (vel_dec <= 6'sd0) begin
            state_d = DESCEND;
          end else begin
            state_d = ASCEND;
          end
        end
        DESCEND: begin
          if (next_h <= 8'sd0) begin
            height_d = 7'd0;
            vel_d    = 6'sd0;
            state_d  = GROUND;
          end else begin
            height_d = next_h[6:0];
            vel_d    = vel_dec;
          end
        end
        default: begin
          state_d  = GROUND;
          height_d = 7'd0;
          vel_d    = 6'sd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Physics state registers.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q   <= GROUND;
      height_q  <= 7'd0;
      vel_q     <= 6'sd0;
      pending_q <= 1'b0;
      jump_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      height_q  <= height_d;
      vel_q     <= vel_d;
      pending_q <= pending_d;
      jump_q    <= jump_d;
    end
  end

  logic frame_sel;

`ifdef DINO_ANIM_EN
  logic [2:0] anim_q, anim_d;

  // Leg-frame counter runs only while standing.
  always_comb begin
    if (tick && (state_q == GROUND)) begin
      anim_d = anim_q + 3'd1;
    end else begin
      anim_d = anim_q;
    end
  end

  // Leg-frame counter register.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      anim_q <= 3'd0;
    end else begin
      anim_q <= anim_d;
    end
  end

  assign frame_sel = (state_q == GROUND) ? anim_q[2] : 1'b0;
`else
  assign frame_sel = 1'b0;
`endif

  // Sprite box; the low 4 bits of the offsets depend only on low 4 bits of the operands.
  logic [9:0] top;
  logic [9:0] row_ext;
  logic       in_box;
  logic [3:0] dy;
  logic [3:0] dx;
  logic       rom_pix;

  assign top     = TOP_REST - {3'b000, height_q};
  assign row_ext = {1'b0, row_addr};
  assign in_box  = (col_addr >= X_LO) && (col_addr <= X_HI) &&
                   (row_ext >= top) && (row_ext <= top + 10'd15);
  assign dy      = row_addr[3:0] - top[3:0];
  assign dx      = col_addr[3:0] - X_LO[3:0];

  dino_rom u_rom (
    .frame (frame_sel),
    .y     (dy),
    .x     (dx),
    .pix   (rom_pix)
  );

  assign px_dinosaur = in_box && rom_pix;
  assign height      = height_q;
  assign airborne    = (state_q != GROUND);

endmodule

// File: tb/tb_dino_sprite.sv
// Randomized scoreboard bench for dino_sprite against a trajectory-queue reference model.
module tb_dino_sprite;

  localparam int DX = 64;
  localparam int GR = 400;
  localparam int JV = 12;
  localparam int GV = 1;

  logic       vga_clk = 1'b0;
  logic       rst = 1'b1;
  logic       jump = 1'b0;
  logic [8:0] row_addr = 9'd0;
  logic [9:0] col_addr = 10'd0;
  logic       px_dinosaur;
  logic [6:0] height;
  logic       airborne;

  always #20 vga_clk = ~vga_clk;

  dino_sprite #(.DINO_X(DX), .GROUND_ROW(GR), .JUMP_V(JV), .GRAVITY(GV)) dut (
    .vga_clk     (vga_clk),
    .rst         (rst),
    .jump        (jump),
    .row_addr    (row_addr),
    .col_addr    (col_addr),
    .px_dinosaur (px_dinosaur),
    .height      (height),
    .airborne    (airborne)
  );

  typedef struct {
    int h;
    int air;
    int px;
    int r;
    int c;
  } exp_t;

  exp_t sbq[$];
  logic probe = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [15:0] f0 [16] = '{16'h007E, 16'h00FF, 16'h00DF, 16'h00FF, 16'h00F0, 16'h00FC,
                           16'h81F0, 16'hC3F0, 16'hE7FC, 16'hFFF4, 16'h7FF0, 16'h3FE0,
                           16'h1FC0, 16'h0D80, 16'h0880, 16'h0CC0};
  logic [15:0] f1 [4]  = '{16'h1F80, 16'h1900, 16'h1100, 16'h1980};
  int exp_list [25] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78, 78,
                        77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};

  // Reference model: future heights queued at acceptance from the closed-form trajectory.
  int traj[$];
  int cur_h = 0;
  bit pend = 1'b0;
  bit jprev = 1'b0;
  int anim = 0;

  function automatic int sprite_bit(int fr, int y, int x);
    logic [15:0] w;
    w = (fr == 1 && y >= 12) ? f1[y-12] : f0[y];
    return int'(w[15-x]);
  endfunction

  function automatic int model_frame();
`ifdef DINO_ANIM_EN
    return (traj.size() == 0) ? ((anim >> 2) & 1) : 0;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_px(int r, int c);
    int top;
    top = GR - 16 - cur_h;
    if (c >= DX && c <= DX + 15 && r >= top && r <= top + 15)
      return sprite_bit(model_frame(), r - top, c - DX);
    return 0;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic cyc(input logic j, input int r, input int c, input bit pr);
    bit tick, rise, ground;
    int h;
    rst = 1'b0;
    jump = j;
    row_addr = 9'(r);
    col_addr = 10'(c);
    probe = pr;
    if (pr) sbq.push_back('{cur_h, (traj.size() > 0) ? 1 : 0, exp_px(r, c), r, c});
    tick = (r == 480 && c == 0);
    rise = j && !jprev;
    ground = (traj.size() == 0);
    if (tick) begin
      if (ground) anim = (anim + 1) % 8;
      if (!ground) begin
        cur_h = traj.pop_front();
      end else if (pend) begin
        for (int k = 1; k < 100; k++) begin
          h = k * JV - GV * k * (k - 1) / 2;
          if (h <= 0) begin
            traj.push_back(0);
            break;
          end
          traj.push_back(h);
        end
      end
      pend = 1'b0;
    end
    if (rise && ground) pend = 1'b1;
    jprev = j;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic rst_cycle();
    rst = 1'b1;
    jump = 1'b0;
    probe = 1'b0;
    row_addr = 9'd0;
    col_addr = 10'd0;
    traj.delete();
    cur_h = 0;
    pend = 1'b0;
    jprev = 1'b0;
    anim = 0;
    @(posedge vga_clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic frame(input logic j, input int np);
    int top, r, c;
    cyc(j, 480, 0, 1'b0);
    for (int p = 0; p < np; p++) begin
      top = GR - 16 - cur_h;
      if ($urandom_range(3) == 0) r = int'($urandom_range(420, 300));
      else r = int'($urandom_range(top + 17, top - 2));
      c = int'($urandom_range(DX + 18, DX - 3));
      cyc(j, r, c, 1'b1);
    end
  endtask

  task automatic jump_run(input int press_idx);
    int air_frames;
    air_frames = 0;
    cyc(1'b1, 100, 10, 1'b0);
    cyc(1'b0, 100, 10, 1'b0);
    frame(1'b0, 2);
    chk("accept_height", int'(height), 0);
    chk("accept_airborne", int'(airborne), 1);
    for (int i = 0; i < 25; i++) begin
      if (airborne) air_frames++;
      if (i == press_idx) begin
        cyc(1'b1, 200, 5, 1'b0);
        cyc(1'b0, 200, 5, 1'b0);
      end
      frame(1'b0, 3);
      chk("traj_height", int'(height), exp_list[i]);
    end
    chk("air_frames", air_frames, 25);
    chk("landed_airborne", int'(airborne), 0);
  endtask

  // Monitor: compares the DUT against the oldest queued expectation on each probe.
  always @(negedge vga_clk) begin
    if (probe) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underflow got empty queue want entry");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        n_checks += 3;
        if (int'(height) != e.h) begin
          n_errors++;
          $display("FAIL height r=%0d c=%0d got %0d want %0d", e.r, e.c, height, e.h);
        end
        if (int'(airborne) != e.air) begin
          n_errors++;
          $display("FAIL airborne r=%0d c=%0d got %0d want %0d", e.r, e.c, airborne, e.air);
        end
        if (int'(px_dinosaur) != e.px) begin
          n_errors++;
          $display("FAIL px r=%0d c=%0d got %0d want %0d", e.r, e.c, px_dinosaur, e.px);
        end
      end
    end
  end

  initial begin
    int guard;
    @(posedge vga_clk);
    #1;
    rst_cycle();
    rst_cycle();

    // Reset state and resting sprite boundaries.
    chk("reset_height", int'(height), 0);
    chk("reset_airborne", int'(airborne), 0);
    for (int c = DX - 4; c <= DX + 19; c++) cyc(1'b0, 399, c, 1'b1);
    for (int c = DX - 4; c <= DX + 19; c++) cyc(1'b0, 400, c, 1'b1);
    for (int c = DX - 1; c <= DX + 16; c++) cyc(1'b0, 384, c, 1'b1);
    cyc(1'b0, 383, DX + 8, 1'b1);

    // Single jump, then a jump with an ignored press at height 50.
    jump_run(-1);
    frame(1'b0, 2);
    jump_run(5);
    frame(1'b0, 2);

    // Press coincident with the tick; held level must not retrigger.
    frame(1'b1, 1);
    chk("coincident_first_tick", int'(airborne), 0);
    frame(1'b1, 1);
    chk("coincident_accept", int'(airborne), 1);
    for (int i = 0; i < 25; i++) frame(1'b1, 2);
    chk("held_landed_height", int'(height), 0);
    chk("held_landed_airborne", int'(airborne), 0);
    for (int i = 0; i < 6; i++) frame(1'b1, 2);
    chk("held_no_retrigger", int'(airborne), 0);
    cyc(1'b0, 10, 10, 1'b0);

    // Reset mid-jump at height 63.
    cyc(1'b1, 100, 10, 1'b0);
    cyc(1'b0, 100, 10, 1'b0);
    guard = 0;
    while (cur_h != 63 && guard < 40) begin
      frame(1'b0, 1);
      guard++;
    end
    chk("midjump_height", int'(height), 63);
    rst_cycle();
    chk("midjump_reset_height", int'(height), 0);
    chk("midjump_reset_airborne", int'(airborne), 0);
    for (int r = 383; r <= 400; r++) cyc(1'b0, r, int'($urandom_range(DX + 16, DX - 1)), 1'b1);

    // Randomized frames with random jump levels.
    for (int i = 0; i < 200; i++) frame(($urandom_range(3) == 0) ? 1'b1 : 1'b0, 3);

    cyc(1'b0, 0, 0, 1'b0);
    cyc(1'b0, 0, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
